// File: rtl/dtpu_host_ctrl.sv
// Host-side controller for dtpu_core: ap_ctrl handshake FSM plus the input and output stream FIFOs.
// FIFOs are first-word fall-through with registered full/empty; handshake outputs decode the state register.

module dtpu_host_fifo #(
   parameter int W     = 65,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr,
   input  logic [W-1:0] din,
   input  logic         rd,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wptr, rptr, wptr_nxt, rptr_nxt;
   logic         push, pop;

   // Gated on the registered flags, so a same-cycle pop never makes room for a push.
   assign push     = wr & ~full;
   assign pop      = rd & ~empty;
   assign wptr_nxt = wptr + (AW+1)'(push);
   assign rptr_nxt = rptr + (AW+1)'(pop);
   assign dout     = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         wptr  <= wptr_nxt;
         rptr  <= rptr_nxt;
         full  <= (wptr_nxt[AW] != rptr_nxt[AW]) && (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
         empty <= (wptr_nxt == rptr_nxt);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= din;
   end
endmodule

module dtpu_host_ctrl #(
   parameter int DATA_WIDTH_FIFO_IN  = 64,
   parameter int DATA_WIDTH_FIFO_OUT = 64,
   parameter int IN_DEPTH            = 16,
   parameter int OUT_DEPTH           = 16
) (
   input  logic                         clk,
   input  logic                         aresetn,
   input  logic [DATA_WIDTH_FIFO_IN:0]  s_tdata,
   input  logic                         s_tvalid,
   output logic                         s_tready,
   output logic [DATA_WIDTH_FIFO_OUT:0] m_tdata,
   output logic                         m_tvalid,
   input  logic                         m_tready,
   output logic [DATA_WIDTH_FIFO_IN:0]  infifo_dout,
   input  logic                         infifo_read,
   output logic                         infifo_is_empty,
   input  logic [DATA_WIDTH_FIFO_OUT:0] outfifo_din,
   input  logic                         outfifo_write,
   output logic                         outfifo_is_full,
   output logic                         cs_start,
   output logic                         cs_continue,
   input  logic                         cs_ready,
   input  logic                         cs_done,
   input  logic                         cs_idle,
   input  logic                         run_req,
   output logic                         run_busy,
   output logic                         run_done,
   output logic [31:0]                  run_cycles,
   output logic                         err_underflow,
   output logic                         err_overflow
);
   typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

   state_t state, state_nxt;
   logic   pend, launch, up;
   logic   in_full, out_empty;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if ((run_req | pend) & cs_idle) state_nxt = START;
         START:   if (cs_ready) state_nxt = cs_done ? DONE : RUN;
         RUN:     if (cs_done) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign launch      = (state == IDLE) && (state_nxt == START);
   assign cs_start    = (state == START);
   assign cs_continue = (state == DONE);
   assign run_done    = (state == DONE);
   assign run_busy    = (state != IDLE);

   // A request seen while the core is not idle waits here (one deep) until cs_idle.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)            pend <= 1'b0;
      else if (state != IDLE)  pend <= 1'b0;
      else if (launch)         pend <= 1'b0;
      else if (run_req)        pend <= 1'b1;
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         run_cycles    <= '0;
         err_underflow <= 1'b0;
         err_overflow  <= 1'b0;
      end else begin
         if (launch)
            run_cycles <= '0;
         else if ((state == START || state == RUN) && run_cycles != 32'hFFFF_FFFF)
            run_cycles <= run_cycles + 32'd1;
         err_underflow <= (err_underflow & ~launch) | (infifo_read & infifo_is_empty);
         err_overflow  <= (err_overflow & ~launch) | (outfifo_write & outfifo_is_full);
      end
   end

   // Holds s_tready low through reset even though the FIFO's full flag resets to 0.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) up <= 1'b0;
      else          up <= 1'b1;
   end

   assign s_tready = up & ~in_full;

   dtpu_host_fifo #(.W(DATA_WIDTH_FIFO_IN + 1), .DEPTH(IN_DEPTH)) u_in_fifo (
      .clk   (clk),
      .rst_n (aresetn),
      .wr    (s_tvalid & s_tready),
      .din   (s_tdata),
      .rd    (infifo_read),
      .dout  (infifo_dout),
      .full  (in_full),
      .empty (infifo_is_empty)
   );

   dtpu_host_fifo #(.W(DATA_WIDTH_FIFO_OUT + 1), .DEPTH(OUT_DEPTH)) u_out_fifo (
      .clk   (clk),
      .rst_n (aresetn),
      .wr    (outfifo_write),
      .din   (outfifo_din),
      .rd    (m_tready),
      .dout  (m_tdata),
      .full  (outfifo_is_full),
      .empty (out_empty)
   );

   assign m_tvalid = ~out_empty;
endmodule

// File: tb/tb_dtpu_host_ctrl.sv
// Scoreboard bench for dtpu_host_ctrl: directed stimulus pushes expectations, a negedge monitor compares.
`timescale 1ns/1ps
module tb_dtpu_host_ctrl;
   logic        clk = 1'b0;
   logic        aresetn;
   logic [64:0] s_tdata, m_tdata, infifo_dout, outfifo_din;
   logic        s_tvalid, s_tready, m_tvalid, m_tready;
   logic        infifo_read, infifo_is_empty, outfifo_write, outfifo_is_full;
   logic        cs_start, cs_continue, cs_ready, cs_done, cs_idle;
   logic        run_req, run_busy, run_done;
   logic [31:0] run_cycles;
   logic        err_underflow, err_overflow;

   int n_cmp = 0;
   int n_bad = 0;
   int in_pops = 0;
   int out_pops = 0;
   logic [64:0] inq[$];
   logic [64:0] outq[$];
   logic [31:0] runq[$];

   always #5 clk = ~clk;

   dtpu_host_ctrl dut (
      .clk(clk), .aresetn(aresetn),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .infifo_dout(infifo_dout), .infifo_read(infifo_read), .infifo_is_empty(infifo_is_empty),
      .outfifo_din(outfifo_din), .outfifo_write(outfifo_write), .outfifo_is_full(outfifo_is_full),
      .cs_start(cs_start), .cs_continue(cs_continue),
      .cs_ready(cs_ready), .cs_done(cs_done), .cs_idle(cs_idle),
      .run_req(run_req), .run_busy(run_busy), .run_done(run_done), .run_cycles(run_cycles),
      .err_underflow(err_underflow), .err_overflow(err_overflow)
   );

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted read-side transfer and every run_done pulse is scored against the queues.
   always @(negedge clk) begin
      if (aresetn) begin
         if (infifo_read && !infifo_is_empty) begin
            in_pops++;
            if (inq.size() == 0) check("infifo_unexpected_pop", infifo_dout, 65'h1_FFFF_FFFF_FFFF_FFFF);
            else check("infifo_dout", infifo_dout, inq.pop_front());
         end
         if (m_tvalid && m_tready) begin
            out_pops++;
            if (outq.size() == 0) check("m_unexpected_pop", m_tdata, 65'h1_FFFF_FFFF_FFFF_FFFF);
            else check("m_tdata", m_tdata, outq.pop_front());
         end
         if (run_done) begin
            if (runq.size() == 0) check("run_done_unexpected", 65'(run_cycles), 65'h1_FFFF_FFFF_FFFF_FFFF);
            else begin
               check("run_cycles_at_done", 65'(run_cycles), 65'(runq.pop_front()));
               check("cs_continue_at_done", 65'(cs_continue), 65'd1);
            end
         end
      end
   end

   initial begin
      int s, os;
      aresetn = 1'b0; s_tdata = '0; s_tvalid = 0; m_tready = 0; infifo_read = 0;
      outfifo_din = '0; outfifo_write = 0; cs_ready = 0; cs_done = 0; cs_idle = 1; run_req = 0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_s_tready", 65'(s_tready), 65'd0);
      check("rst_cs_start", 65'(cs_start), 65'd0);
      check("rst_in_empty", 65'(infifo_is_empty), 65'd1);
      check("rst_out_full", 65'(outfifo_is_full), 65'd0);
      check("rst_m_tvalid", 65'(m_tvalid), 65'd0);
      aresetn = 1'b1;
      tick();
      check("idle_s_tready", 65'(s_tready), 65'd1);
      check("idle_busy", 65'(run_busy), 65'd0);
      check("idle_continue", 65'(cs_continue), 65'd0);
      check("idle_run_done", 65'(run_done), 65'd0);
      check("idle_cycles", 65'(run_cycles), 65'd0);
      check("idle_errs", 65'({err_underflow, err_overflow}), 65'd0);

      // Run 1: 3 START cycles + 6 RUN cycles = 9
      run_req = 1; tick(); run_req = 0;
      check("run1_cs_start", 65'(cs_start), 65'd1);
      check("run1_busy", 65'(run_busy), 65'd1);
      tick(); tick();
      cs_ready = 1; tick(); cs_ready = 0;
      check("run1_start_dropped", 65'(cs_start), 65'd0);
      check("run1_in_run_busy", 65'(run_busy), 65'd1);
      repeat (5) tick();
      runq.push_back(32'd9);
      cs_done = 1; tick(); cs_done = 0;
      check("run1_run_done", 65'(run_done), 65'd1);
      tick();
      check("run1_continue_one_cycle", 65'(cs_continue), 65'd0);
      check("run1_back_idle", 65'(run_busy), 65'd0);
      check("run1_cycles_hold", 65'(run_cycles), 65'd9);

      // Pending request guarded by cs_idle, then ready+done together in first START cycle
      cs_idle = 0; run_req = 1; tick(); run_req = 0; tick();
      check("pend_no_start", 65'(cs_start), 65'd0);
      check("pend_not_busy", 65'(run_busy), 65'd0);
      cs_idle = 1; tick();
      check("pend_start", 65'(cs_start), 65'd1);
      check("pend_cycles_cleared", 65'(run_cycles), 65'd0);
      runq.push_back(32'd1);
      cs_ready = 1; cs_done = 1; tick(); cs_ready = 0; cs_done = 0;
      check("fast_done", 65'(run_done), 65'd1);
      tick();

      // Input FIFO fill, blocked push during pop, drain, underflow
      for (int i = 0; i < 16; i++) begin
         s_tvalid = 1; s_tdata = {(i == 15), 64'(i)};
         inq.push_back(s_tdata);
         tick();
      end
      check("in_full_tready", 65'(s_tready), 65'd0);
      s_tdata = 65'd77; infifo_read = 1;
      tick();
      s_tvalid = 0;
      repeat (15) tick();
      infifo_read = 0;
      check("in_drained_empty", 65'(infifo_is_empty), 65'd1);
      check("in_no_underflow_yet", 65'(err_underflow), 65'd0);
      infifo_read = 1; tick(); infifo_read = 0;
      check("in_underflow", 65'(err_underflow), 65'd1);
      check("in_still_empty", 65'(infifo_is_empty), 65'd1);
      s_tvalid = 1; s_tdata = 65'h1_0000_0000_0000_0ABC; inq.push_back(s_tdata);
      tick(); s_tvalid = 0;
      check("in_after_underflow_nonempty", 65'(infifo_is_empty), 65'd0);
      infifo_read = 1; tick(); infifo_read = 0;

      // Output FIFO overflow and drain
      for (int i = 0; i < 17; i++) begin
         outfifo_write = 1; outfifo_din = 65'(500 + i);
         if (i < 16) outq.push_back(outfifo_din);
         tick();
      end
      outfifo_write = 0;
      check("out_full", 65'(outfifo_is_full), 65'd1);
      check("out_overflow", 65'(err_overflow), 65'd1);
      check("out_m_tvalid", 65'(m_tvalid), 65'd1);
      m_tready = 1; repeat (16) tick(); m_tready = 0;
      check("out_drained", 65'(m_tvalid), 65'd0);
      check("out_not_full", 65'(outfifo_is_full), 65'd0);

      // Short run clears the sticky error flags
      runq.push_back(32'd1);
      run_req = 1; tick(); run_req = 0;
      cs_ready = 1; cs_done = 1; tick(); cs_ready = 0; cs_done = 0;
      tick();
      check("errs_cleared", 65'({err_underflow, err_overflow}), 65'd0);

      // Wrap-around with random valid/ready
      in_pops = 0; out_pops = 0; s = 0; os = 0;
      for (int c = 0; c < 3000 && (in_pops < 40 || out_pops < 40); c++) begin
         s_tvalid = (s < 40) && ($urandom_range(0, 1) == 1);
         s_tdata = 65'(1000 + s);
         if (s_tvalid && s_tready) begin inq.push_back(s_tdata); s++; end
         infifo_read = ($urandom_range(0, 1) == 1) && !infifo_is_empty;
         outfifo_write = (os < 40) && !outfifo_is_full && ($urandom_range(0, 1) == 1);
         outfifo_din = 65'(2000 + os);
         if (outfifo_write) begin outq.push_back(outfifo_din); os++; end
         m_tready = ($urandom_range(0, 1) == 1);
         tick();
      end
      s_tvalid = 0; infifo_read = 0; outfifo_write = 0; m_tready = 0;
      check("wrap_in_count", 65'(in_pops), 65'd40);
      check("wrap_out_count", 65'(out_pops), 65'd40);
      check("wrap_errs", 65'({err_underflow, err_overflow}), 65'd0);

      // Reset during an active run with words queued
      run_req = 1; tick(); run_req = 0;
      for (int i = 0; i < 5; i++) begin
         s_tvalid = 1; s_tdata = 65'(300 + i);
         outfifo_write = 1; outfifo_din = 65'(400 + i);
         tick();
      end
      s_tvalid = 0; outfifo_write = 0;
      check("mid_cs_start", 65'(cs_start), 65'd1);
      check("mid_in_nonempty", 65'(infifo_is_empty), 65'd0);
      aresetn = 0; #2;
      check("mid_rst_cs_start", 65'(cs_start), 65'd0);
      check("mid_rst_busy", 65'(run_busy), 65'd0);
      check("mid_rst_in_empty", 65'(infifo_is_empty), 65'd1);
      check("mid_rst_m_tvalid", 65'(m_tvalid), 65'd0);
      inq.delete(); outq.delete();
      @(posedge clk); #1; aresetn = 1;
      tick();
      check("post_rst_cs_start", 65'(cs_start), 65'd0);
      check("post_rst_busy", 65'(run_busy), 65'd0);
      check("post_rst_cycles", 65'(run_cycles), 65'd0);
      check("post_rst_in_empty", 65'(infifo_is_empty), 65'd1);
      check("post_rst_m_tvalid", 65'(m_tvalid), 65'd0);
      check("post_rst_s_tready", 65'(s_tready), 65'd1);

      tick();
      check("sb_in_left", 65'(inq.size()), 65'd0);
      check("sb_out_left", 65'(outq.size()), 65'd0);
      check("sb_run_left", 65'(runq.size()), 65'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
